counter_step_sequencer: RTL
===========================

# counter_step_sequencer

Command-driven sequencer that owns an 8-bit counter and applies host-issued operations to it: clear, load, and paced up/down stepping. Commands arrive as single-cycle strobes from a trigger/wire endpoint pair on `sys_clk`, are queued in a small FIFO, and execute one at a time. Status, count and one-cycle event pulses are exported so they can be wired to wire-out and trigger-out endpoints.

## Interface
- `DIV_WIDTH`, 24: width of the step-interval input.
- `FIFO_DEPTH`, 4: command queue depth; power of two, ≥2.
- `sys_clk`  in  1  sole clock; all logic is synchronous to it.
- `reset_n`  in  1  synchronous, active-low reset.
- `cmd_valid`  in  1  one-cycle strobe; `cmd_word` is offered this cycle.
- `cmd_word`  in  16  [15:14] opcode (00 CLEAR, 01 UP, 10 DOWN, 11 LOAD); [13:8] ignored; [7:0] arg.
- `step_div`  in  DIV_WIDTH  cycles between successive steps; 0 is treated as 1.
- `abort`  in  1  one-cycle strobe; flush queue and stop the current op.
- `cmd_ready`  out  1  high when queue level < FIFO_DEPTH.
- `count`  out  8  counter value.
- `busy`  out  1  executing a command or queue non-empty.
- `done_pulse`  out  1  one cycle per completed command.
- `wrap_pulse`  out  1  one cycle when a step wraps FF→00 or 00→FF.
- `overflow`  out  1  sticky; a command was dropped because the queue was full.
- `fifo_level`  out  log2(FIFO_DEPTH)+1  queued commands, excluding the executing one.

## Operation
- Push: `cmd_valid` && `cmd_ready` (registered level < FIFO_DEPTH) enqueues `cmd_word`. A pop in the same cycle does not make room.
- `cmd_valid` while `cmd_ready`=0: the command is dropped and `overflow` is set.
- States: IDLE, EXEC, WAIT.
  - IDLE, queue non-empty: pop the head. Latch op, arg, and `max(step_div,1)` as D. Go to EXEC.
  - EXEC, CLEAR: count←0x00, done, go to IDLE.
  - EXEC, LOAD: count←arg, done, go to IDLE.
  - EXEC, UP/DOWN with arg=0: count unchanged, done, go to IDLE.
  - EXEC, UP/DOWN with arg=N>0: apply one step (±1, modulo 256) and set remaining=N−1. If remaining=0: done, go to IDLE. Otherwise go to WAIT.
  - WAIT: hold D−1 cycles, then apply the next step. Repeat until remaining=0, then done and go to IDLE.
- Only the latched D governs a running command; `step_div` changes apply to later commands.
- `wrap_pulse` is generated only by UP/DOWN steps, never by LOAD or CLEAR.
- Abort (priority below reset, above everything else):
  - Queue emptied; state→IDLE.
  - Any pending step is cancelled; `count` holds its value.
  - No `done_pulse`; `overflow` cleared.
  - A `cmd_valid` in the same cycle is discarded and does not set `overflow`.
- Reset: every register is cleared. `count`=0, `busy`=0, `done_pulse`=0, `wrap_pulse`=0, `overflow`=0, `fifo_level`=0, `cmd_ready`=1.

## Timing
- Push at edge T0: `fifo_level` increments at T0+1.
- If IDLE with an empty queue at T0+1, the pop occurs at T0+1 (`fifo_level` decrements at T0+2). EXEC runs in cycle T0+2.
- A count update made in EXEC is visible at T0+3.
- For UP/DOWN N>0, count changes are visible at T0+3, T0+3+D, …, T0+3+(N−1)·D.
- `done_pulse` is asserted in the cycle the command's final count first becomes visible (T0+3 for CLEAR/LOAD/N≤1).
- State is IDLE in that same cycle, so a queued next command pops immediately. Minimum pitch is 2 cycles per command.
- `wrap_pulse` is coincident with the wrapped `count` value.
- `busy` = (state≠IDLE) || level≠0, registered. It rises at T0+1 after a push and falls in the cycle after the final `done_pulse` with an empty queue.
- Abort sampled at edge Ta: `busy`=0, `fifo_level`=0 and `overflow`=0 at Ta+1.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles → `count`=0, `busy`=0, `cmd_ready`=1, `fifo_level`=0, all pulses 0.
- LOAD 0x10, then UP 3 with `step_div`=4 → `count` 0x10 with `done_pulse`; then 0x11, 0x12, 0x13 spaced exactly 4 cycles apart; a single `done_pulse` coincident with 0x13.
- From 0x00, DOWN 2 with `step_div`=0 → 0xFF with `wrap_pulse`, next cycle 0xFE with `done_pulse`; `wrap_pulse` fires once.
- UP 255 with `step_div`=1000, then 5 more pushes while it runs → 4 accepted, `fifo_level`=4, `cmd_ready`=0; 5th dropped, `overflow`=1.
- `abort` during the above → `count` frozen at its current value, `fifo_level`=0, `busy`=0, `overflow`=0, no `done_pulse` in the following 2000 cycles.
- `reset_n` low mid-UP with a queue of 3 → all outputs reach reset values after the next edge; no `done_pulse` after release.

Source files
------------

// File: rtl/counter_step_sequencer.sv
// Command-queued 8-bit counter sequencer: CLEAR / LOAD / paced UP-DOWN stepping,
// with a small command FIFO, abort flush and one-cycle done/wrap event pulses.
module counter_step_sequencer #(
  parameter int DIV_WIDTH  = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         sys_clk,
  input  logic                         reset_n,
  input  logic                         cmd_valid,
  input  logic [15:0]                  cmd_word,
  input  logic [DIV_WIDTH-1:0]         step_div,
  input  logic                         abort,
  output logic                         cmd_ready,
  output logic [7:0]                   count,
  output logic                         busy,
  output logic                         done_pulse,
  output logic                         wrap_pulse,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [PTR_W:0]     DEPTH_L  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]     LVL_ZERO = {(PTR_W+1){1'b0}};
  localparam logic [PTR_W:0]     LVL_ONE  = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0]   PTR_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]   PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_UP    = 2'b01;
  localparam logic [1:0] OP_DOWN  = 2'b10;
  localparam logic [1:0] OP_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_WAIT = 2'b10
  } state_t;

  state_t                 state_q, state_d;
  logic [9:0]             fifo_mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         level_q, level_d;
  logic [1:0]             op_q, op_d;
  logic [7:0]             rem_q, rem_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   wait_q, wait_d;
  logic [7:0]             count_q, count_d;
  logic                   done_q, done_d;
  logic                   wrap_q, wrap_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;

  logic                   ready_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   step_s;
  logic [9:0]             head_s;
  logic [DIV_WIDTH-1:0]   div_eff_s;
  logic                   unused_word_s;

  assign unused_word_s = ^cmd_word[13:8];

  // Room is judged on the registered level so a same-cycle pop never frees a slot.
  assign ready_s   = (level_q < DEPTH_L);
  assign push_s    = cmd_valid && ready_s && !abort;
  assign pop_s     = (state_q == ST_IDLE) && (level_q != LVL_ZERO) && !abort;
  assign head_s    = fifo_mem_q[rd_ptr_q];
  assign div_eff_s = (step_div == DIV_ZERO) ? DIV_ONE : step_div;

  // Queue pointers, level and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (abort) begin
      wr_ptr_d   = PTR_ZERO;
      rd_ptr_d   = PTR_ZERO;
      level_d    = LVL_ZERO;
      overflow_d = 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
      if (cmd_valid && !ready_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_UP, OP_DOWN: begin
            if (rem_q <= 8'd1) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_WAIT;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
      ST_WAIT: begin
        if ((wait_q == DIV_ZERO) && (rem_q == 8'd1)) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Datapath and event pulses; an abort freezes count and suppresses every pulse.
  always_comb begin
    op_d    = op_q;
    rem_d   = rem_q;
    div_d   = div_q;
    wait_d  = wait_q;
    count_d = count_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    step_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pop_s) begin
          op_d  = head_s[9:8];
          rem_d = head_s[7:0];
          div_d = div_eff_s;
        end else begin
          op_d  = op_q;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_CLEAR: begin
            count_d = 8'h00;
            done_d  = 1'b1;
          end
          OP_LOAD: begin
            count_d = rem_q;
            done_d  = 1'b1;
          end
          default: begin
            if (rem_q == 8'd0) begin
              done_d = 1'b1;
            end else begin
              step_s = 1'b1;
              done_d = (rem_q == 8'd1);
            end
          end
        endcase
      end
      ST_WAIT: begin
        if (wait_q == DIV_ZERO) begin
          step_s = 1'b1;
          done_d = (rem_q == 8'd1);
        end else begin
          wait_d = wait_q - DIV_ONE;
        end
      end
      default: begin
        done_d = 1'b0;
      end
    endcase
    if (step_s) begin
      rem_d  = rem_q - 8'd1;
      wait_d = div_q - DIV_ONE;
      if (op_q == OP_UP) begin
        count_d = count_q + 8'd1;
        wrap_d  = (count_q == 8'hFF);
      end else begin
        count_d = count_q - 8'd1;
        wrap_d  = (count_q == 8'h00);
      end
    end else begin
      rem_d = rem_d;
    end
    if (abort) begin
      count_d = count_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
    end else begin
      count_d = count_d;
    end
  end

  // Busy stays high through the cycle that carries the final done pulse.
  always_comb begin
    if (abort) begin
      busy_d = 1'b0;
    end else begin
      busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE) || (level_d != LVL_ZERO);
    end
  end

  // Command storage.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 10'd0;
      end
    end else if (push_s) begin
      fifo_mem_q[wr_ptr_q] <= {cmd_word[15:14], cmd_word[7:0]};
    end
  end

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Remaining registers.
  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= LVL_ZERO;
      overflow_q <= 1'b0;
      op_q       <= OP_CLEAR;
      rem_q      <= 8'd0;
      div_q      <= DIV_ZERO;
      wait_q     <= DIV_ZERO;
      count_q    <= 8'd0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      op_q       <= op_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      wait_q     <= wait_d;
      count_q    <= count_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
      busy_q     <= busy_d;
    end
  end

  assign cmd_ready  = ready_s;
  assign count      = count_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign wrap_pulse = wrap_q;
  assign overflow   = overflow_q;
  assign fifo_level = level_q;

endmodule
